ga_eval_scheduler: RTL and testbench
====================================

Name: ga_eval_scheduler

Overview:
Synthesizable controller that sequences fitness evaluation of a stored GA population of 24-bit FSM chromosomes. On each start it reads every chromosome from an external population memory, steps the chromosome-encoded 3-state Mealy FSM over the configured input sequence at one bit per cycle, scores the output against the expected sequence, writes each fitness to a fitness memory, and tracks the best chromosome. It sits between the population store and the GA crossover/mutation stage.

Parameters:
POP_SIZE, 32, number of chromosomes per generation
SEQ_LEN, 5, bits in the input and expected sequences
FIT_W, 4, fitness width; must hold 3*SEQ_LEN
MAX_FITNESS, 7, early-stop threshold (used only with the optional feature)
ADDR_W, 5, population address width, $clog2(POP_SIZE)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  begin evaluating one generation; sampled only in IDLE
clear_best  in  1  sampled together with an accepted start; clears the best registers
input_seq  in  SEQ_LEN  stimulus, applied MSB first
expected  in  SEQ_LEN  expected outputs, MSB first
mem_rd_en  out  1  population read strobe
mem_rd_addr  out  ADDR_W  chromosome index
mem_rd_data  in  24  chromosome, valid the cycle after mem_rd_en
fit_wr_en  out  1  fitness write strobe
fit_wr_addr  out  ADDR_W  chromosome index
fit_wr_data  out  FIT_W  computed fitness
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at the end of a generation
max_reached  out  1  early stop occurred; held until the next accepted start
best_chrom  out  24  best chromosome so far
best_fit  out  FIT_W  fitness of best_chrom
best_idx  out  ADDR_W  index of best_chrom in the generation that set it

Behaviour:
- Reset: all outputs 0, state IDLE, best registers 0. Applies at any state, including mid-run; no fitness write in the reset cycle. rst wins over start.
- States: IDLE -> FETCH -> WAIT -> STEP (SEQ_LEN cycles) -> WRITE -> FETCH (next index) or DONE -> IDLE.
- IDLE: start=1 loads input_seq/expected into internal copies, sets index=0, clears max_reached, and clears the best registers when clear_best=1. start is ignored while busy.
- FETCH: mem_rd_en=1, mem_rd_addr=index.
- WAIT: capture mem_rd_data; FSM state s=0; step counter k=0; accumulator acc=0.
- Chromosome decode, STEP k: in = input_seq[SEQ_LEN-1-k]; e = 4*(2*s+in); next state = chrom[e+2:e] mod 3; out = chrom[e+3]. Next-state values 3..7 wrap through mod 3; state 3 is unreachable.
- Scoring, STEP k: if out == expected[SEQ_LEN-1-k], acc += 3 when the expected bit is 1, otherwise acc += 1.
- WRITE: fit_wr_en=1, fit_wr_addr=index, fit_wr_data=acc. If acc > best_fit (strictly greater, so ties keep the earlier chromosome), update best_chrom/best_fit/best_idx; new values are visible the next cycle. Go to DONE if index == POP_SIZE-1, otherwise increment index and go to FETCH.
- Latency: SEQ_LEN+3 cycles per chromosome. With start sampled at cycle 0, chromosome j is written at cycle (SEQ_LEN+3)*(j+1). done pulses at cycle (SEQ_LEN+3)*POP_SIZE+1, which is 257 at the defaults. busy is high from cycle 1 through the done cycle.
- Best registers persist across generations unless cleared by rst or by start with clear_best=1.

Optional Feature:
GA_EARLY_STOP_EN
- Defined: in WRITE, if acc >= MAX_FITNESS, go to DONE regardless of index, set max_reached=1 and issue no further reads.
- Undefined: the full population is always evaluated and max_reached stays 0.

Test Plan:
1. Default sequences 00101/00001, chromosome 0x000000 at every index -> every fit_wr_data = 4, best_fit = 4, best_idx = 0, done at cycle 257.
2. Chromosome 0x901210 (ideal 101 detector) at index 0, all others 0x000000 -> fit[0] = 7, best_chrom = 0x901210, best_idx = 0.
3. 0xFFFFFF at every index -> output sequence 11111, every fitness = 3. Run a second start with clear_best=0 after test 2: best stays 0x901210/7.
4. 0x901210 at indices 3 and 9, feature off -> best_idx = 3, 32 fitness writes, max_reached = 0.
5. GA_EARLY_STOP_EN defined, 0x901210 at index 5 -> writes only to addresses 0..5, done at cycle 49, max_reached = 1.
6. start pulsed at cycle 20 while busy -> ignored. rst at cycle 30 -> outputs 0 and state IDLE next cycle, no fit_wr_en. A new start then runs cleanly to done.

Source files
------------

// File: rtl/ga_eval_scheduler_if.sv
// Memory-side bus of the GA fitness evaluation scheduler: population read port
// and fitness write port. The scheduler is the master; the memories are the slave.
interface ga_eval_scheduler_if #(
    parameter int ADDR_W = 5,
    parameter int FIT_W  = 4
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [23:0]       mem_rd_data;
    logic              fit_wr_en;
    logic [ADDR_W-1:0] fit_wr_addr;
    logic [FIT_W-1:0]  fit_wr_data;

    modport master (
        output mem_rd_en,
        output mem_rd_addr,
        input  mem_rd_data,
        output fit_wr_en,
        output fit_wr_addr,
        output fit_wr_data
    );

    modport slave (
        input  mem_rd_en,
        input  mem_rd_addr,
        output mem_rd_data,
        input  fit_wr_en,
        input  fit_wr_addr,
        input  fit_wr_data
    );
endinterface

// File: rtl/ga_eval_scheduler.sv
// Sequences fitness evaluation of a GA population of 24-bit 3-state Mealy FSM chromosomes.
// Optional early stop on reaching MAX_FITNESS is enabled by defining GA_EARLY_STOP_EN.
module ga_eval_scheduler #(
    parameter int POP_SIZE    = 32,
    parameter int SEQ_LEN     = 5,
    parameter int FIT_W       = 4,
    parameter int MAX_FITNESS = 7,
    parameter int ADDR_W      = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                clear_best,
    input  logic [SEQ_LEN-1:0]  input_seq,
    input  logic [SEQ_LEN-1:0]  expected,
    ga_eval_scheduler_if.master bus,
    output logic                busy,
    output logic                done,
    output logic                max_reached,
    output logic [23:0]         best_chrom,
    output logic [FIT_W-1:0]    best_fit,
    output logic [ADDR_W-1:0]   best_idx
);

    localparam int K_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam logic [FIT_W-1:0]  MAX_FIT_V = FIT_W'(MAX_FITNESS);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(POP_SIZE - 1);
    localparam logic [K_W-1:0]    LAST_STEP = K_W'(SEQ_LEN - 1);

`ifdef GA_EARLY_STOP_EN
    localparam bit EARLY_STOP = 1'b1;
`else
    localparam bit EARLY_STOP = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_STEP,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [SEQ_LEN-1:0] seq_reg;
    logic [SEQ_LEN-1:0] exp_reg;
    logic [SEQ_LEN-1:0] in_sh;
    logic [SEQ_LEN-1:0] exp_sh;
    logic [ADDR_W-1:0]  index;
    logic [23:0]        chrom_reg;
    logic [1:0]         fsm_s;
    logic [K_W-1:0]     k;
    logic [FIT_W-1:0]   acc;

    logic               cur_in;
    logic               cur_exp;
    logic [3:0]         nib;
    logic               step_out;
    logic [1:0]         step_next;
    logic [FIT_W-1:0]   score_inc;
    logic               last_idx;
    logic               last_step;
    logic               stop_hit;

    function automatic logic [1:0] mod3(input logic [2:0] v);
        logic [1:0] r;
        case (v)
            3'd0, 3'd3, 3'd6: r = 2'd0;
            3'd1, 3'd4, 3'd7: r = 2'd1;
            default:          r = 2'd2;
        endcase
        return r;
    endfunction

    assign cur_in    = in_sh[SEQ_LEN-1];
    assign cur_exp   = exp_sh[SEQ_LEN-1];
    assign last_idx  = (index == LAST_IDX);
    assign last_step = (k == LAST_STEP);
    assign stop_hit  = EARLY_STOP && (acc >= MAX_FIT_V);

    // Transition nibble for (state, input) lives at bit 4*(2*s+in) of the chromosome.
    always_comb begin
        nib = 4'd0;
        case ({fsm_s, cur_in})
            3'd0:    nib = chrom_reg[3:0];
            3'd1:    nib = chrom_reg[7:4];
            3'd2:    nib = chrom_reg[11:8];
            3'd3:    nib = chrom_reg[15:12];
            3'd4:    nib = chrom_reg[19:16];
            3'd5:    nib = chrom_reg[23:20];
            default: nib = 4'd0;
        endcase
    end

    assign step_out  = nib[3];
    assign step_next = mod3(nib[2:0]);

    always_comb begin
        score_inc = '0;
        if (step_out == cur_exp) begin
            score_inc = cur_exp ? FIT_W'(3) : FIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Strobes are forced low while rst is high so a reset landing on WRITE never commits.
    always_comb begin
        next_state      = state;
        busy            = (state != S_IDLE);
        done            = 1'b0;
        bus.mem_rd_en   = 1'b0;
        bus.mem_rd_addr = '0;
        bus.fit_wr_en   = 1'b0;
        bus.fit_wr_addr = '0;
        bus.fit_wr_data = '0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                bus.mem_rd_en   = 1'b1;
                bus.mem_rd_addr = index;
                next_state      = S_WAIT;
            end
            S_WAIT: begin
                next_state = S_STEP;
            end
            S_STEP: begin
                if (last_step) begin
                    next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                bus.fit_wr_en   = 1'b1;
                bus.fit_wr_addr = index;
                bus.fit_wr_data = acc;
                if (last_idx || stop_hit) begin
                    next_state = S_DONE;
                end else begin
                    next_state = S_FETCH;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase

        if (rst) begin
            busy            = 1'b0;
            done            = 1'b0;
            bus.mem_rd_en   = 1'b0;
            bus.mem_rd_addr = '0;
            bus.fit_wr_en   = 1'b0;
            bus.fit_wr_addr = '0;
            bus.fit_wr_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_reg     <= '0;
            exp_reg     <= '0;
            in_sh       <= '0;
            exp_sh      <= '0;
            index       <= '0;
            chrom_reg   <= '0;
            fsm_s       <= '0;
            k           <= '0;
            acc         <= '0;
            max_reached <= 1'b0;
            best_chrom  <= '0;
            best_fit    <= '0;
            best_idx    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        seq_reg     <= input_seq;
                        exp_reg     <= expected;
                        index       <= '0;
                        max_reached <= 1'b0;
                        if (clear_best) begin
                            best_chrom <= '0;
                            best_fit   <= '0;
                            best_idx   <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    chrom_reg <= bus.mem_rd_data;
                    fsm_s     <= '0;
                    k         <= '0;
                    acc       <= '0;
                    in_sh     <= seq_reg;
                    exp_sh    <= exp_reg;
                end
                S_STEP: begin
                    fsm_s  <= step_next;
                    acc    <= acc + score_inc;
                    k      <= k + K_W'(1);
                    in_sh  <= in_sh << 1;
                    exp_sh <= exp_sh << 1;
                end
                S_WRITE: begin
                    // Strict compare keeps the earliest chromosome on a tie.
                    if (acc > best_fit) begin
                        best_chrom <= chrom_reg;
                        best_fit   <= acc;
                        best_idx   <= index;
                    end
                    if (stop_hit) begin
                        max_reached <= 1'b1;
                    end else if (!last_idx) begin
                        index <= index + ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ga_eval_scheduler.sv
// Directed, table-driven bench for ga_eval_scheduler with hand-computed expectations.
module tb_ga_eval_scheduler;

`ifdef GA_EARLY_STOP_EN
    localparam bit ES = 1'b1;
`else
    localparam bit ES = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic        clear_best;
    logic [4:0]  input_seq;
    logic [4:0]  expected;
    logic        busy;
    logic        done;
    logic        max_reached;
    logic [23:0] best_chrom;
    logic [3:0]  best_fit;
    logic [4:0]  best_idx;

    logic [23:0] pop [32];
    int          fit_mem [32];
    int          vec_cnt = 0;
    int          fail_cnt = 0;

    ga_eval_scheduler_if #(.ADDR_W(5), .FIT_W(4)) bus ();

    ga_eval_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .clear_best (clear_best),
        .input_seq  (input_seq),
        .expected   (expected),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .max_reached(max_reached),
        .best_chrom (best_chrom),
        .best_fit   (best_fit),
        .best_idx   (best_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Population memory: one-cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_rd_en) begin
            bus.mem_rd_data <= pop[bus.mem_rd_addr];
        end
    end

    typedef struct {
        string       name;
        logic [23:0] base;
        logic [23:0] spec;
        int          sa;
        int          sb;
        logic [4:0]  iseq;
        logic [4:0]  eseq;
        bit          clr;
        int          fit_base;
        int          fit_spec;
        logic [23:0] b_chrom;
        int          b_fit;
        int          b_idx;
        int          n_wr;
        int          done_cyc;
        bit          maxr;
    } vec_t;

    vec_t vecs [7];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        vec_cnt++;
        if (act !== req) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic loadPop(input logic [23:0] base, input logic [23:0] spec, input int sa, input int sb);
        for (int i = 0; i < 32; i++) begin
            pop[i]     = (i == sa || i == sb) ? spec : base;
            fit_mem[i] = -1;
        end
    endtask

    // Runs one generation from a start pulse; cycle numbers count from the start-sampling edge.
    task automatic applyStimulus(input logic [4:0] iseq, input logic [4:0] eseq, input bit clr,
                                 output int done_cyc, output int n_wr, output int n_rd,
                                 output int order_err, output int busy_err, output int pulse_err);
        done_cyc  = -1;
        n_wr      = 0;
        n_rd      = 0;
        order_err = 0;
        busy_err  = 0;
        pulse_err = 0;
        @(negedge clk);
        input_seq  = iseq;
        expected   = eseq;
        clear_best = clr;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        clear_best = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (!busy) busy_err++;
            if (bus.mem_rd_en) begin
                if (bus.mem_rd_addr != 5'(n_rd)) order_err++;
                n_rd++;
            end
            if (bus.fit_wr_en) begin
                if (bus.fit_wr_addr != 5'(n_wr)) order_err++;
                fit_mem[bus.fit_wr_addr] = int'(bus.fit_wr_data);
                n_wr++;
            end
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        @(negedge clk);
        if (done || busy) pulse_err = 1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int dc, nw, nr, oe, be, pe, nbad, ex;

        vecs[0] = '{"all_zero",  24'h000000, 24'h000000, -1, -1, 5'b00101, 5'b00001, 1'b1,
                    4, 0, 24'h000000, 4, 0, 32, 257, 1'b0};
        vecs[1] = '{"ideal_at0", 24'h000000, 24'h901210,  0, -1, 5'b00101, 5'b00001, 1'b1,
                    4, 7, 24'h901210, 7, 0, ES ? 1 : 32, ES ? 9 : 257, ES};
        vecs[2] = '{"all_ones_keep", 24'hFFFFFF, 24'h000000, -1, -1, 5'b00101, 5'b00001, 1'b0,
                    3, 0, 24'h901210, 7, 0, 32, 257, 1'b0};
        vecs[3] = '{"ideal_3_9_tie", 24'h000000, 24'h901210,  3,  9, 5'b00101, 5'b00001, 1'b1,
                    4, 7, 24'h901210, 7, 3, ES ? 4 : 32, ES ? 33 : 257, ES};
        vecs[4] = '{"ideal_at5", 24'h000000, 24'h901210,  5, -1, 5'b00101, 5'b00001, 1'b1,
                    4, 7, 24'h901210, 7, 5, ES ? 6 : 32, ES ? 49 : 257, ES};
        vecs[5] = '{"max_fit15", 24'hFFFFFF, 24'h000000, -1, -1, 5'b11111, 5'b11111, 1'b1,
                    15, 0, 24'hFFFFFF, 15, 0, ES ? 1 : 32, ES ? 9 : 257, ES};
        vecs[6] = '{"mod3_wrap", 24'h000000, 24'hF76D43,  7, -1, 5'b00101, 5'b00001, 1'b1,
                    4, 6, 24'hF76D43, 6, 7, 32, 257, 1'b0};

        rst        = 1'b1;
        start      = 1'b0;
        clear_best = 1'b0;
        input_seq  = 5'b00101;
        expected   = 5'b00001;
        loadPop(24'h0, 24'h0, -1, -1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_done", 32'(done), 0);
        checkOutput("reset_best_chrom", 32'(best_chrom), 0);
        checkOutput("reset_best_fit", 32'(best_fit), 0);
        checkOutput("reset_strobes", 32'({bus.mem_rd_en, bus.fit_wr_en, max_reached}), 0);
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            loadPop(vecs[v].base, vecs[v].spec, vecs[v].sa, vecs[v].sb);
            applyStimulus(vecs[v].iseq, vecs[v].eseq, vecs[v].clr, dc, nw, nr, oe, be, pe);
            nbad = 0;
            for (int i = 0; i < 32; i++) begin
                if (i >= vecs[v].n_wr) ex = -1;
                else if (i == vecs[v].sa || i == vecs[v].sb) ex = vecs[v].fit_spec;
                else ex = vecs[v].fit_base;
                if (fit_mem[i] != ex) nbad++;
            end
            checkOutput({vecs[v].name, " done_cycle"}, 32'(dc), 32'(vecs[v].done_cyc));
            checkOutput({vecs[v].name, " writes"}, 32'(nw), 32'(vecs[v].n_wr));
            checkOutput({vecs[v].name, " reads"}, 32'(nr), 32'(vecs[v].n_wr));
            checkOutput({vecs[v].name, " addr_order_errs"}, 32'(oe), 0);
            checkOutput({vecs[v].name, " busy_gaps"}, 32'(be), 0);
            checkOutput({vecs[v].name, " done_pulse_errs"}, 32'(pe), 0);
            checkOutput({vecs[v].name, " fit_mem_bad"}, 32'(nbad), 0);
            checkOutput({vecs[v].name, " fit_idx0"}, 32'(fit_mem[0]),
                        32'((vecs[v].sa == 0) ? vecs[v].fit_spec : vecs[v].fit_base));
            checkOutput({vecs[v].name, " best_chrom"}, 32'(best_chrom), 32'(vecs[v].b_chrom));
            checkOutput({vecs[v].name, " best_fit"}, 32'(best_fit), 32'(vecs[v].b_fit));
            checkOutput({vecs[v].name, " best_idx"}, 32'(best_idx), 32'(vecs[v].b_idx));
            checkOutput({vecs[v].name, " max_reached"}, 32'(max_reached), 32'(vecs[v].maxr));
        end

        // Start while busy is ignored, mid-run reset returns to IDLE, then a clean rerun.
        loadPop(24'h0, 24'h0, -1, -1);
        @(negedge clk);
        clear_best = 1'b1;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        clear_best = 1'b0;
        for (int c = 1; c <= 31; c++) begin
            @(negedge clk);
            if (c == 8) begin
                checkOutput("seq_wr_en_c8", 32'(bus.fit_wr_en), 1);
                checkOutput("seq_best_fit_c8", 32'(best_fit), 0);
            end
            if (c == 9) checkOutput("seq_best_fit_c9", 32'(best_fit), 4);
            if (c == 20) start = 1'b1;
            if (c == 21) start = 1'b0;
            if (c == 24) begin
                checkOutput("seq_wr_en_c24", 32'(bus.fit_wr_en), 1);
                checkOutput("seq_wr_addr_c24", 32'(bus.fit_wr_addr), 2);
            end
            if (c == 30) begin
                rst = 1'b1;
                #1;
                checkOutput("seq_rst_wr_en_c30", 32'(bus.fit_wr_en), 0);
            end
            if (c == 31) begin
                checkOutput("seq_rst_busy_c31", 32'(busy), 0);
                checkOutput("seq_rst_best_fit_c31", 32'(best_fit), 0);
                checkOutput("seq_rst_strobes_c31", 32'({bus.mem_rd_en, bus.fit_wr_en, done}), 0);
                rst = 1'b0;
            end
        end
        applyStimulus(5'b00101, 5'b00001, 1'b1, dc, nw, nr, oe, be, pe);
        checkOutput("rerun done_cycle", 32'(dc), 257);
        checkOutput("rerun writes", 32'(nw), 32);
        checkOutput("rerun best_fit", 32'(best_fit), 4);

        // Reset landing exactly on a WRITE cycle must suppress that write.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            if (c == 16) begin
                rst = 1'b1;
                #1;
                checkOutput("rst_in_write_wr_en", 32'(bus.fit_wr_en), 0);
            end
            if (c == 17) begin
                checkOutput("rst_in_write_busy", 32'(busy), 0);
                rst = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
        $finish;
    end

endmodule
